alu_issue_ctrl: RTL and testbench

//  Drives the RISC datapath ALU and holds an 8-entry register file. Accepts one 16-bit instruction
//  (valid/ready) and decodes its opcode into alu_control. Presents operands to the ALU, captures

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_issue_ctrl_if.sv | 24 ++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, ALU function codes, FSM states
// and the opcode decoder.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_EQ  = 4'b1010;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_NOT = 5'b00010;
    localparam logic [4:0] ALU_SHL = 5'b00011;
    localparam logic [4:0] ALU_SHR = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;
    localparam logic [4:0] ALU_EQ  = 5'b00111;
    localparam logic [4:0] ALU_SLT = 5'b01000;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    typedef struct packed {
        logic       legal;
        logic [4:0] ctrl;
    } decode_t;

    // Illegal opcodes decode to ALU_ADD with legal=0 so alu_control stays well defined.
    function automatic decode_t decode_op(input logic [3:0] op);
        decode_t d;
        d.legal = 1'b1;
        d.ctrl  = ALU_ADD;
        case (op)
            OP_ADD:  d.ctrl = ALU_ADD;
            OP_SUB:  d.ctrl = ALU_SUB;
            OP_NOT:  d.ctrl = ALU_NOT;
            OP_SHL:  d.ctrl = ALU_SHL;
            OP_SHR:  d.ctrl = ALU_SHR;
            OP_AND:  d.ctrl = ALU_AND;
            OP_OR:   d.ctrl = ALU_OR;
            OP_SLT:  d.ctrl = ALU_SLT;
            OP_EQ:   d.ctrl = ALU_EQ;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in and writeback-out handshake bundle of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_zero;
    logic [2:0]        out_rd;
    logic              out_err;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_rd, out_err
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_rd, out_err
    );
endinterface

// File: rtl/alu_regfile.sv
// Register file: r0 reads zero, two operand read ports plus a debug port, one synchronous
// write port, cleared by the asynchronous reset.
module alu_regfile #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);
    localparam int NumRegs = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
    assign dbg_data  = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serial issue controller: accepts one instruction, drives the external ALU from registers,
// writes the result back to the register file and returns it on the writeback port.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_issue_ctrl_if.slave       bus,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [4:0]            alu_control,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    output logic [CNT_W-1:0]      retired,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);
    state_e                state_q, state_d;
    logic [15:3]           instr_q;
    decode_t               dec;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic [DATA_W-1:0]     rs1_data, rs2_data;
    logic [DATA_W-1:0]     alu_a_q, alu_b_q;
    logic [4:0]            alu_ctrl_q;
    logic [DATA_W-1:0]     out_data_q;
    logic                  out_zero_q, out_err_q;
    logic [2:0]            out_rd_q;
    logic [CNT_W-1:0]      retired_q;
    logic                  in_ready, out_valid, accept, wr_en;

    assign rs1    = instr_q[11:9];
    assign rs2    = instr_q[8:6];
    assign rd     = instr_q[5:3];
    assign dec    = decode_op(instr_q[15:12]);
    assign accept = bus.in_valid && in_ready;

    alu_regfile #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_addr_a(rs1),
        .rd_data_a(rs1_data),
        .rd_addr_b(rs2),
        .rd_data_b(rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (rd),
        .wr_data  (alu_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRead;
            StRead:  state_d = dec.legal ? StExec : StWb;
            StExec:  state_d = StWb;
            StWb:    if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StWb);
        wr_en     = (state_q == StExec) && (rd != '0);
    end

    // ALU pins only change on the READ edge, so they are stable across the whole EXEC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            out_data_q <= '0;
            out_zero_q <= 1'b0;
            out_err_q  <= 1'b0;
            out_rd_q   <= '0;
            retired_q  <= '0;
        end else begin
            if (accept) begin
                instr_q <= bus.in_instr[15:3];
            end
            if (state_q == StRead) begin
                alu_a_q    <= rs1_data;
                alu_b_q    <= rs2_data;
                alu_ctrl_q <= dec.ctrl;
                if (!dec.legal) begin
                    out_err_q  <= 1'b1;
                    out_data_q <= '0;
                    out_zero_q <= 1'b0;
                    out_rd_q   <= rd;
                end
            end
            if (state_q == StExec) begin
                out_data_q <= alu_result;
                out_zero_q <= alu_zero;
                out_err_q  <= 1'b0;
                out_rd_q   <= rd;
            end
            if ((state_q == StWb) && bus.out_ready) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_err   = out_err_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_control   = alu_ctrl_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, reference register model and a
// writeback scoreboard.
module tb_alu_issue_ctrl;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [4:0]        alu_control;
    logic              alu_zero;
    logic [CNT_W-1:0]  retired;
    logic [2:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(DATA_W)) bus ();

    alu_issue_ctrl #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_control(alu_control),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .retired    (retired),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Combinational ALU the controller drives.
    always_comb begin
        case (alu_control)
            5'b00000: alu_result = alu_a + alu_b;
            5'b00001: alu_result = alu_a - alu_b;
            5'b00010: alu_result = ~alu_a;
            5'b00011: alu_result = alu_a << alu_b[3:0];
            5'b00100: alu_result = alu_a >> alu_b[3:0];
            5'b00101: alu_result = alu_a & alu_b;
            5'b00110: alu_result = alu_a | alu_b;
            5'b00111: alu_result = (alu_a == alu_b) ? 16'd8 : 16'd9;
            5'b01000: alu_result = (alu_a < alu_b) ? 16'd7 : 16'd5;
            default:  alu_result = 16'hDEAD;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic [15:0] data;
        logic        zero;
        logic [2:0]  rd;
        logic        err;
    } rec_t;

    rec_t             sb[$];
    logic [15:0]      ref_regs [8];
    logic [CNT_W-1:0] retired_exp;
    int               errors = 0;
    int               checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rs1,
                                        input logic [2:0] rs2, input logic [2:0] rd);
        return {op, rs1, rs2, rd, 3'b000};
    endfunction

    function automatic logic [4:0] exp_ctrl(input logic [3:0] op);
        case (op)
            4'h2:    return 5'b00000;
            4'h3:    return 5'b00001;
            4'h4:    return 5'b00010;
            4'h5:    return 5'b00011;
            4'h6:    return 5'b00100;
            4'h7:    return 5'b00101;
            4'h8:    return 5'b00110;
            4'h9:    return 5'b01000;
            4'hA:    return 5'b00111;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic bit model_alu(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b, output logic [15:0] res);
        res = '0;
        case (op)
            4'h2:    res = a + b;
            4'h3:    res = a - b;
            4'h4:    res = ~a;
            4'h5:    res = a << b[3:0];
            4'h6:    res = a >> b[3:0];
            4'h7:    res = a & b;
            4'h8:    res = a | b;
            4'h9:    res = (a < b) ? 16'd7 : 16'd5;
            4'hA:    res = (a == b) ? 16'd8 : 16'd9;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_val(tag, dbg_data, ref_regs[i]);
        end
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        retired_exp = '0;
    endtask

    task automatic run_instr(input logic [15:0] instr, input int hold);
        logic [15:0] a, b, res;
        bit          legal;
        rec_t        exp, got;
        int          edges;
        a     = ref_regs[instr[11:9]];
        b     = ref_regs[instr[8:6]];
        legal = model_alu(instr[15:12], a, b, res);
        exp.err  = !legal;
        exp.data = legal ? res : 16'h0;
        exp.zero = legal && (res == 16'h0);
        exp.rd   = instr[5:3];
        sb.push_back(exp);

        edges = 0;
        while (!bus.in_ready && edges < 10) begin
            @(negedge clk);
            edges++;
        end
        check_val("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_instr = ~instr;
        edges = 1;
        while (!bus.out_valid && edges < 10) begin
            if (edges == 2 && legal) begin
                check_val("exec_ctrl", alu_control, exp_ctrl(instr[15:12]));
                check_val("exec_ops", {alu_a, alu_b}, {a, b});
                check_val("exec_in_ready", bus.in_ready, 0);
            end
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check_val("latency", edges, legal ? 3 : 2);

        if (sb.size() == 0) begin
            check_val("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            check_val("out_data", bus.out_data, got.data);
            check_val("out_zero", bus.out_zero, got.zero);
            check_val("out_rd", bus.out_rd, got.rd);
            check_val("out_err", bus.out_err, got.err);
        end

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("wb_hold", {bus.out_valid, bus.in_ready, bus.out_data, bus.out_err},
                      {1'b1, 1'b0, exp.data, exp.err});
        end

        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        retired_exp = retired_exp + 1'b1;
        check_val("retired", retired, retired_exp);
        check_val("out_valid_drop", bus.out_valid, 0);
        if (legal && instr[5:3] != 3'd0) ref_regs[instr[5:3]] = res;
    endtask

    initial begin
        bus.in_instr = '0;
        dbg_addr     = '0;
        apply_reset();

        // Reset / idle state
        @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_in_ready", bus.in_ready, 1);
        check_val("rst_alu_ctrl", alu_control, 0);
        check_val("rst_retired", retired, 0);
        check_all_regs("rst_dbg");

        // Seed r1=5, r4=8, r2=3 from zero registers, then the sub under test
        run_instr(enc(4'h2, 3'd0, 3'd0, 3'd1), 0);
        run_instr(enc(4'h9, 3'd0, 3'd0, 3'd1), 0);
        run_instr(enc(4'hA, 3'd0, 3'd0, 3'd4), 0);
        run_instr(enc(4'h3, 3'd4, 3'd1, 3'd2), 0);
        check_all_regs("seed_dbg");
        run_instr(16'b0011_001_010_011_000, 0);
        check_all_regs("sub_dbg");

        // slt, eq, sub-to-zero
        run_instr(enc(4'h9, 3'd2, 3'd1, 3'd5), 0);
        run_instr(enc(4'hA, 3'd1, 3'd1, 3'd6), 0);
        run_instr(enc(4'h3, 3'd1, 3'd1, 3'd7), 0);
        check_all_regs("cmp_dbg");

        // Illegal opcode and rd=0 writes
        run_instr(enc(4'hF, 3'd1, 3'd2, 3'd3), 0);
        run_instr(enc(4'h2, 3'd1, 3'd2, 3'd0), 0);
        check_all_regs("illegal_dbg");

        // Backpressure in WB
        run_instr(enc(4'h8, 3'd1, 3'd2, 3'd6), 5);

        // Reset while in EXEC
        bus.in_valid = 1'b1;
        bus.in_instr = enc(4'h3, 3'd1, 3'd2, 3'd3);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("midrst_outs", {bus.out_valid, bus.out_data, bus.out_err}, 0);
        check_val("midrst_alu", {alu_a, alu_b, alu_control}, 0);
        check_val("midrst_ready", bus.in_ready, 1);
        check_val("midrst_retired", retired, 0);
        apply_reset();
        check_all_regs("midrst_dbg");

        // Counter wrap: 2^CNT_W retirements bring it back to zero
        run_instr(enc(4'h9, 3'd0, 3'd0, 3'd1), 0);
        run_instr(enc(4'hA, 3'd0, 3'd0, 3'd2), 0);
        run_instr(enc(4'h4, 3'd0, 3'd0, 3'd3), 0);
        for (int i = 0; i < 12; i++) begin
            run_instr(enc(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))), 0);
        end
        check_val("retired_max", retired, {CNT_W{1'b1}});
        run_instr(enc(4'h5, 3'd1, 3'd1, 3'd4), 0);
        check_val("retired_wrap", retired, 0);
        check_all_regs("final_dbg");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
